// File: rtl/spram_bist_pkg.sv
// spram_bist_pkg
//   Shared definitions for the spram March C- BIST controller.
//   - FSM state encodings (IDLE, M0, RD1, WR1, RD2, WR2, M3, DRAIN, DONE).
//   - op_t: per-state RAM operation decode (write/read/active/inverted data).
//   - decode_op(): maps a state to its RAM operation and data-polarity select.
//     The same polarity bit picks the write data (P or ~P) in write states
//     and the expected read data (P or ~P) in read states.
package spram_bist_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_M0    = 4'd1;
  localparam logic [3:0] ST_RD1   = 4'd2;
  localparam logic [3:0] ST_WR1   = 4'd3;
  localparam logic [3:0] ST_RD2   = 4'd4;
  localparam logic [3:0] ST_WR2   = 4'd5;
  localparam logic [3:0] ST_M3    = 4'd6;
  localparam logic [3:0] ST_DRAIN = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  typedef struct packed {
    logic active;  // state owns the RAM port (an M* state)
    logic we;      // write cycle
    logic rd;      // read cycle, result compared next cycle
    logic inv;     // data is ~P instead of P
  } op_t;

  // March element decode. Data polarity by element:
  //   M0 write P, M1 read P / write ~P, M2 read ~P / write P, M3 read P.
  function automatic op_t decode_op(input logic [3:0] st);
    op_t op;
    op = '0;
    case (st)
      ST_M0:  begin op.active = 1'b1; op.we = 1'b1; end
      ST_RD1: begin op.active = 1'b1; op.rd = 1'b1; end
      ST_WR1: begin op.active = 1'b1; op.we = 1'b1; op.inv = 1'b1; end
      ST_RD2: begin op.active = 1'b1; op.rd = 1'b1; op.inv = 1'b1; end
      ST_WR2: begin op.active = 1'b1; op.we = 1'b1; end
      ST_M3:  begin op.active = 1'b1; op.rd = 1'b1; end
      default: ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/spram_bist_checker.sv
// spram_bist_checker
//   Compare stage of the BIST. A read issued in cycle n is registered here
//   (vld/addr/exp) and compared against mem_dout in cycle n+1.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clr             synchronous clear of the compare stage and all results
//     cmp_vld         current cycle is a RAM read to be checked
//     cmp_addr        address of that read
//     cmp_exp         expected data of that read
//     mem_dout        RAM read data (valid the cycle after the read)
//     err_count       saturating mismatch count
//     fail_addr       address of the first mismatch
//     fail_expected   expected data of the first mismatch
//     fail_actual     observed data of the first mismatch
module spram_bist_checker #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 8,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cmp_vld,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  input  logic [WIDTH-1:0]      cmp_exp,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_expected,
  output logic [WIDTH-1:0]      fail_actual
);

  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      exp_q;
  logic                  mismatch;

  assign mismatch = vld_q && (mem_dout != exp_q);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q         <= 1'b0;
      addr_q        <= '0;
      exp_q         <= '0;
      err_count     <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      vld_q  <= cmp_vld;
      addr_q <= cmp_addr;
      exp_q  <= cmp_exp;
      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + ERR_W'(1);
        end
        // Only the first failure of a run is recorded.
        if (err_count == '0) begin
          fail_addr     <= addr_q;
          fail_expected <= exp_q;
          fail_actual   <= mem_dout;
        end
      end
    end
  end

endmodule

// File: rtl/spram_bist.sv
// spram_bist
//   March C- built-in self-test controller for a synchronous single-port RAM.
//   Sequence (one RAM op per cycle):
//     M0 up: w P | M1 up: r P, w ~P | M2 down: r ~P, w P | M3 up: r P
//     then one DRAIN cycle for the last compare, then DONE.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           begin a test; accepted in IDLE or DONE
//     mem_we/addr/din RAM write/read port (zero outside the march states)
//     mem_dout        RAM read data, valid one cycle after a read
//     busy            test in progress (6*DEPTH+1 cycles)
//     done            test finished, held until next accepted start or rst
//     pass            done with zero mismatches
//     err_count       saturating mismatch count
//     fail_addr/fail_expected/fail_actual   first mismatch details
module spram_bist
  import spram_bist_pkg::*;
#(
  parameter int              DEPTH   = 256,
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = 8'h55,
  parameter int              ERR_W   = 8,
  localparam int             ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_din,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_expected,
  output logic [WIDTH-1:0]      fail_actual
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [3:0]            state;
  logic [3:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  accept;
  op_t                   op;
  logic [WIDTH-1:0]      data_sel;

  // DONE behaves like IDLE for start so a held start reruns immediately.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_M0;
          addr_nxt  = '0;
        end
      end
      ST_M0: begin
        if (addr == LAST_ADDR) begin
          state_nxt = ST_RD1;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + ADDR_WIDTH'(1);
        end
      end
      ST_RD1: state_nxt = ST_WR1;
      ST_WR1: begin
        if (addr == LAST_ADDR) begin
          state_nxt = ST_RD2;  // M2 starts from the top, address stays
        end else begin
          state_nxt = ST_RD1;
          addr_nxt  = addr + ADDR_WIDTH'(1);
        end
      end
      ST_RD2: state_nxt = ST_WR2;
      ST_WR2: begin
        if (addr == '0) begin
          state_nxt = ST_M3;   // M3 starts from 0, address stays
        end else begin
          state_nxt = ST_RD2;
          addr_nxt  = addr - ADDR_WIDTH'(1);
        end
      end
      ST_M3: begin
        if (addr == LAST_ADDR) begin
          state_nxt = ST_DRAIN;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  // RAM port and compare request decode straight from registered state.
  assign op       = decode_op(state);
  assign data_sel = op.inv ? ~PATTERN : PATTERN;
  assign mem_we   = op.we;
  assign mem_addr = op.active ? addr : '0;
  assign mem_din  = op.we ? data_sel : '0;

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

  spram_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (WIDTH),
    .ERR_W      (ERR_W)
  ) u_checker (
    .clk           (clk),
    .rst           (rst),
    .clr           (accept),
    .cmp_vld       (op.rd),
    .cmp_addr      (addr),
    .cmp_exp       (data_sel),
    .mem_dout      (mem_dout),
    .err_count     (err_count),
    .fail_addr     (fail_addr),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

endmodule

// File: tb/tb_spram_bist.sv
// tb_spram_bist
//   Directed bench for spram_bist (DEPTH=16, WIDTH=8, PATTERN=8'h55, ERR_W=4)
//   with a synchronous RAM model that has stuck-at and aliasing fault hooks.
module tb_spram_bist;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int ERR_W = 4;
  localparam int AW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [AW-1:0]    fail_addr;
  logic [WIDTH-1:0] fail_expected, fail_actual;

  spram_bist #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .PATTERN (8'h55),
    .ERR_W   (ERR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .fail_addr     (fail_addr),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

  // RAM model with fault hooks
  logic [WIDTH-1:0] ram [DEPTH];
  logic             sa_en, sa_all, alias_en;
  logic [AW-1:0]    sa_addr;
  logic [WIDTH-1:0] sa_mask;
  logic [AW-1:0]    phys;
  logic [WIDTH-1:0] rd_mask;

  // Aliasing fault: address 11 decodes onto word 3 (addr[3] ignored there).
  always_comb phys = (alias_en && mem_addr == 4'd11) ? 4'd3 : mem_addr;
  always_comb rd_mask = sa_all ? 8'hFF :
                        ((sa_en && mem_addr == sa_addr) ? sa_mask : 8'h00);

  always @(posedge clk) begin
    if (mem_we) ram[phys] <= mem_din;
    else        mem_dout  <= ram[phys] & ~rd_mask;
  end

  // scoreboard counters
  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected RAM port activity for busy cycle i (0-based), DEPTH=16.
  function automatic logic [16:0] exp_port(input int i);
    logic we;
    logic [3:0] a;
    logic [7:0] d;
    int j;
    we = 1'b0; a = 4'd0; d = 8'h00;
    if (i < 16) begin
      we = 1'b1; a = 4'(i); d = 8'h55;
    end else if (i < 48) begin
      j = i - 16; we = (j % 2) == 1; a = 4'(j / 2); d = we ? 8'hAA : 8'h00;
    end else if (i < 80) begin
      j = i - 48; we = (j % 2) == 1; a = 4'(15 - j / 2); d = we ? 8'h55 : 8'h00;
    end else if (i < 96) begin
      a = 4'(i - 80);
    end
    return {we, a, d};
  endfunction

  // Runs from the first busy cycle until busy drops (bounded). Returns the
  // number of busy cycles and the number of cycles whose RAM port differed
  // from the expected march sequence.
  task automatic run_test(input int pulse_at, input bit hold, output int n, output int bad);
    n = 0;
    bad = 0;
    while (busy && n < 200) begin
      n++;
      if ({mem_we, mem_addr, mem_din} !== exp_port(n - 1)) bad++;
      start = hold || (n == pulse_at);
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int n, bad;

  initial begin
    rst = 1'b1; start = 1'b0;
    sa_en = 1'b0; sa_all = 1'b0; alias_en = 1'b0; sa_addr = '0; sa_mask = '0;
    repeat (3) step();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    check("rst_err", err_count, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_exp", fail_expected, 0);
    check("rst_fail_act", fail_actual, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // 1. fault-free run
    pulse_start();
    check("t1_busy_first", busy, 1);
    run_test(0, 0, n, bad);
    check("t1_busy_cycles", n, 97);
    check("t1_port_seq", bad, 0);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    step(); step();
    check("t1_done_held", done, 1);

    // 2. bit 0 stuck-at-0 at address 5
    sa_en = 1'b1; sa_addr = 4'd5; sa_mask = 8'h01;
    pulse_start();
    check("t2_done_clr", done, 0);
    run_test(0, 0, n, bad);
    check("t2_busy_cycles", n, 97);
    check("t2_pass", pass, 0);
    check("t2_err", err_count, 2);
    check("t2_fail_addr", fail_addr, 5);
    check("t2_fail_exp", fail_expected, 8'h55);
    check("t2_fail_act", fail_actual, 8'h54);
    sa_en = 1'b0;

    // 3. address 11 aliases onto word 3
    alias_en = 1'b1;
    pulse_start();
    run_test(0, 0, n, bad);
    check("t3_err_nonzero", (err_count != 0), 1);
    check("t3_pass", pass, 0);
    check("t3_fail_addr", fail_addr, 11);
    check("t3_fail_exp", fail_expected, 8'h55);
    check("t3_fail_act", fail_actual, 8'hAA);
    alias_en = 1'b0;

    // 4. reset for one cycle at busy cycle 40 (addr 5 fault already seen)
    sa_en = 1'b1; sa_addr = 4'd5; sa_mask = 8'h01;
    pulse_start();
    repeat (39) step();
    check("t4_err_before_rst", err_count, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_we", mem_we, 0);
    check("t4_err", err_count, 0);
    check("t4_fail_addr", fail_addr, 0);
    sa_en = 1'b0;
    step();
    pulse_start();
    run_test(0, 0, n, bad);
    check("t4_rerun_cycles", n, 97);
    check("t4_rerun_seq", bad, 0);
    check("t4_rerun_pass", pass, 1);

    // 5. start pulsed mid-run is ignored
    pulse_start();
    run_test(20, 0, n, bad);
    check("t5_busy_cycles", n, 97);
    check("t5_done", done, 1);
    check("t5_pass", pass, 1);

    // 6. every bit stuck-at-0 everywhere
    sa_all = 1'b1;
    pulse_start();
    run_test(0, 0, n, bad);
    check("t6_err_sat", err_count, 4'hF);
    check("t6_pass", pass, 0);
    check("t6_fail_addr", fail_addr, 0);
    check("t6_fail_exp", fail_expected, 8'h55);
    check("t6_fail_act", fail_actual, 8'h00);
    sa_all = 1'b0;

    // start after done clears results in the next cycle and reruns
    pulse_start();
    check("t5b_done_clr", done, 0);
    check("t5b_pass_clr", pass, 0);
    check("t5b_err_clr", err_count, 0);
    check("t5b_fail_act_clr", fail_actual, 0);
    check("t5b_busy", busy, 1);
    run_test(0, 0, n, bad);
    check("t5b_cycles", n, 97);
    check("t5b_pass", pass, 1);

    // start held high: done lasts one cycle, then the test reruns
    pulse_start();
    run_test(0, 1, n, bad);
    check("hold_cycles", n, 97);
    check("hold_done", done, 1);
    step();
    start = 1'b0;
    check("hold_done_one_cycle", done, 0);
    check("hold_rerun_busy", busy, 1);
    run_test(0, 0, n, bad);
    check("hold_rerun_cycles", n, 97);
    check("hold_rerun_pass", pass, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
